// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 cascade driver: FSM state encoding and
// counter sizing helper.
package hc595_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hc595_tick_gen.sv
// Clock divider with enable and clear: one-cycle tick every CLK_DIV enabled
// cycles. Paces both the SH_CP half-periods and the ST_CP high time.
module hc595_tick_gen
  import hc595_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(CLK_DIV - 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Down-counter; clear holds it at the reload value so the first enabled
  // period after a clear is a full CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hc595_chain_driver.sv
// Serialises a CHAIN_BITS word onto DS/SH_CP for a 74HC595 cascade, then
// pulses ST_CP to latch it. Load/Busy/Done handshake, Auto_EN refresh.
//
// state    | meaning
// ST_IDLE  | waiting for Load or Auto_EN; DS holds last bit, clocks low
// ST_SHIFT | clocking bits out, CLK_DIV cycles low then CLK_DIV high per bit
// ST_LATCH | ST_CP high for CLK_DIV cycles, Done pulses on exit
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int CHAIN_BITS = 16,
  parameter int CLK_DIV    = 2,
  parameter int LSB_FIRST  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [CHAIN_BITS-1:0] Data,
  input  logic                  Load,
  input  logic                  Auto_EN,
  output logic                  Busy,
  output logic                  Done,
  output logic                  SH_CP,
  output logic                  ST_CP,
  output logic                  DS
);

  localparam int BW = cnt_width(CHAIN_BITS);

  logic [1:0]            state;
  logic [CHAIN_BITS-1:0] sh_reg;
  logic [CHAIN_BITS-1:0] sh_next;
  logic [BW-1:0]         bits_left;
  logic                  start;
  logic                  tick;
  logic                  tick_clr;
  logic                  last_bit;

  assign start    = Load | Auto_EN;
  assign Busy     = (state != ST_IDLE);
  assign tick_clr = (state == ST_IDLE);
  assign last_bit = (bits_left == '0);

  function automatic logic out_bit(input logic [CHAIN_BITS-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[CHAIN_BITS-1];
  endfunction

  always_comb begin
    sh_next = (LSB_FIRST != 0) ? (sh_reg >> 1) : (sh_reg << 1);
  end

  hc595_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (Clk),
    .rst_n(Rst_n),
    .en   (Busy),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      sh_reg    <= '0;
      bits_left <= '0;
      SH_CP     <= 1'b0;
      ST_CP     <= 1'b0;
      DS        <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh_reg    <= Data;
            DS        <= out_bit(Data);
            SH_CP     <= 1'b0;
            ST_CP     <= 1'b0;
            bits_left <= BW'(CHAIN_BITS - 1);
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!SH_CP) begin
              SH_CP <= 1'b1;
            end else begin
              SH_CP <= 1'b0;
              // The falling edge of the last bit doubles as the latch rise.
              if (last_bit) begin
                ST_CP <= 1'b1;
                state <= ST_LATCH;
              end else begin
                sh_reg    <= sh_next;
                DS        <= out_bit(sh_next);
                bits_left <= bits_left - 1'b1;
              end
            end
          end
        end
        ST_LATCH: begin
          if (tick) begin
            ST_CP <= 1'b0;
            Done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: a default instance (16 bits, /2, MSB first)
// and a small one (8 bits, /1, LSB first), both checked against a timing model.
module tb_hc595_chain_driver;

  localparam int NA = 16;
  localparam int DA = 2;
  localparam int LA = 0;
  localparam int NB = 8;
  localparam int DB = 1;
  localparam int LB = 1;

  logic clk = 1'b0;
  logic rst_n;

  logic        load_a, auto_a;
  logic [15:0] data_a;
  logic        busy_a, done_a, sh_cp_a, st_cp_a, ds_a;
  logic        load_b, auto_b;
  logic [7:0]  data_b;
  logic        busy_b, done_b, sh_cp_b, st_cp_b, ds_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hc595_chain_driver dut_a (
    .Clk(clk), .Rst_n(rst_n), .Data(data_a), .Load(load_a), .Auto_EN(auto_a),
    .Busy(busy_a), .Done(done_a), .SH_CP(sh_cp_a), .ST_CP(st_cp_a), .DS(ds_a)
  );

  hc595_chain_driver #(.CHAIN_BITS(NB), .CLK_DIV(DB), .LSB_FIRST(LB)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Data(data_b), .Load(load_b), .Auto_EN(auto_b),
    .Busy(busy_b), .Done(done_b), .SH_CP(sh_cp_b), .ST_CP(st_cp_b), .DS(ds_b)
  );

  // Event monitors: edge counts and the DS value seen at each SH_CP rise.
  int          edge_cnt = 0;
  int          rises_a = 0, st_rises_a = 0, st_hi_a = 0, dones_a = 0;
  int          rises_b = 0, busy_hi_b = 0;
  logic [15:0] cap_a = '0;
  logic [7:0]  cap_b = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge sh_cp_a) begin
    rises_a <= rises_a + 1;
    cap_a   <= {cap_a[14:0], ds_a};
  end

  always @(posedge st_cp_a) st_rises_a <= st_rises_a + 1;

  always @(posedge sh_cp_b) begin
    rises_b <= rises_b + 1;
    cap_b   <= {ds_b, cap_b[7:1]};
  end

  always @(negedge clk) begin
    if (st_cp_a) st_hi_a <= st_hi_a + 1;
    if (done_a) dones_a <= dones_a + 1;
    if (busy_b) busy_hi_b <= busy_hi_b + 1;
  end

  // Model: a transfer is just "started at edge t0 with word w"; outputs are
  // pure arithmetic on the cycle offset c since t0.
  function automatic logic bit_of(input int lsb, input int n, input logic [15:0] w, input int k);
    int idx;
    idx = (lsb != 0) ? k : (n - 1 - k);
    return w[idx];
  endfunction

  function automatic logic [4:0] model_out(input int n, input int d, input int lsb, input logic act,
                                           input int c, input logic [15:0] w, input logic hold);
    int   ts;
    logic ds;
    ts = 2 * d * n;
    if (!act) return {4'b0000, hold};
    ds = (c < ts) ? bit_of(lsb, n, w, c / (2 * d)) : bit_of(lsb, n, w, n - 1);
    return {c < ts + d, c == ts + d, (c < ts) && ((c / d) % 2 == 1), (c >= ts) && (c < ts + d), ds};
  endfunction

  logic        ma_act, mb_act, ma_hold, mb_hold;
  int          ma_c, mb_c;
  logic [15:0] ma_word, mb_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_act <= 1'b0; ma_c <= 0; ma_word <= '0; ma_hold <= 1'b0;
    end else if (!ma_act || ma_c == DA * (2 * NA + 1)) begin
      if (ma_act) ma_hold <= bit_of(LA, NA, ma_word, NA - 1);
      ma_act <= load_a | auto_a;
      ma_c   <= 0;
      if (load_a | auto_a) ma_word <= data_a;
    end else begin
      ma_c <= ma_c + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_act <= 1'b0; mb_c <= 0; mb_word <= '0; mb_hold <= 1'b0;
    end else if (!mb_act || mb_c == DB * (2 * NB + 1)) begin
      if (mb_act) mb_hold <= bit_of(LB, NB, mb_word, NB - 1);
      mb_act <= load_b | auto_b;
      mb_c   <= 0;
      if (load_b | auto_b) mb_word <= {8'h00, data_b};
    end else begin
      mb_c <= mb_c + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_load_a(input logic [15:0] d, output int e0);
    @(posedge clk); #1;
    data_a = d;
    load_a = 1'b1;
    @(posedge clk); #1;
    load_a = 1'b0;
    e0 = edge_cnt;
  endtask

  task automatic pulse_load_b(input logic [7:0] d, output int e0);
    @(posedge clk); #1;
    data_b = d;
    load_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b0;
    e0 = edge_cnt;
  endtask

  task automatic wait_done_a(input string tag, output int e_done);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (done_a) seen = 1'b1;
    end
    e_done = edge_cnt;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_done_b(input string tag, output int e_done);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (done_b) seen = 1'b1;
    end
    e_done = edge_cnt;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  e0, ed, ed1, r0, s0, h0, d0, b0, n;
    bit  seen;

    rst_n  = 1'b0;
    load_a = 1'b0; auto_a = 1'b1; data_a = 16'hAF65;
    load_b = 1'b0; auto_b = 1'b0; data_b = 8'h00;

    fork
      forever begin
        @(negedge clk);
        check("a_outputs", 32'({busy_a, done_a, sh_cp_a, st_cp_a, ds_a}),
              32'(model_out(NA, DA, LA, ma_act, ma_c, ma_word, ma_hold)));
        check("b_outputs", 32'({busy_b, done_b, sh_cp_b, st_cp_b, ds_b}),
              32'(model_out(NB, DB, LB, mb_act, mb_c, mb_word, mb_hold)));
      end
    join_none

    // Reset held with Auto_EN high: nothing may move.
    repeat (20) @(posedge clk);
    #1;
    check("rst_outputs", 32'({busy_a, done_a, sh_cp_a, st_cp_a, ds_a}), 32'd0);
    check("rst_sh_rises", rises_a, 32'd0);
    check("rst_st_rises", st_rises_a, 32'd0);
    auto_a = 1'b0;
    rst_n  = 1'b1;

    // Single MSB-first frame.
    r0 = rises_a; s0 = st_rises_a; h0 = st_hi_a;
    pulse_load_a(16'hAF65, e0);
    wait_done_a("t2", ed);
    check("t2_done_latency", ed - e0, 32'd66);
    check("t2_sh_rises", rises_a - r0, 32'd16);
    check("t2_ds_word", 32'(cap_a), 32'hAF65);
    check("t2_st_rises", st_rises_a - s0, 32'd1);
    check("t2_st_high", st_hi_a - h0, 32'd2);

    // LSB-first, 8 bits, divider 1.
    r0 = rises_b; b0 = busy_hi_b;
    pulse_load_b(8'h01, e0);
    wait_done_b("t3", ed);
    check("t3_done_latency", ed - e0, 32'd17);
    check("t3_sh_rises", rises_b - r0, 32'd8);
    check("t3_ds_word", 32'(cap_b), 32'h01);
    check("t3_busy_cycles", busy_hi_b - b0, 32'd17);

    // Continuous refresh with Data changing mid-frame.
    r0 = rises_a;
    @(posedge clk); #1;
    data_a = 16'hAF65;
    auto_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    data_a = 16'h55A5;
    wait_done_a("t4a", ed1);
    check("t4_frame1", 32'(cap_a), 32'hAF65);
    check("t4_done_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("t4_no_gap", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    auto_a = 1'b0;
    wait_done_a("t4b", ed);
    check("t4_frame2", 32'(cap_a), 32'h55A5);
    check("t4_frame_spacing", ed - ed1, 32'd67);
    check("t4_sh_rises", rises_a - r0, 32'd32);
    repeat (20) @(negedge clk);
    check("t4_stopped", 32'(busy_a), 32'd0);

    // Load+Auto together, then Loads while Busy: still a single frame.
    r0 = rises_a; s0 = st_rises_a; d0 = dones_a;
    @(posedge clk); #1;
    data_a = 16'h3C96; load_a = 1'b1; auto_a = 1'b1;
    @(posedge clk); #1;
    load_a = 1'b0; auto_a = 1'b0; data_a = 16'hFFFF;
    repeat (5) @(posedge clk);
    #1 load_a = 1'b1;
    @(posedge clk);
    #1 load_a = 1'b0;
    repeat (30) @(posedge clk);
    #1 load_a = 1'b1; data_a = 16'h0000;
    @(posedge clk);
    #1 load_a = 1'b0;
    wait_done_a("t5", ed);
    check("t5_ds_word", 32'(cap_a), 32'h3C96);
    repeat (20) @(negedge clk);
    check("t5_dones", dones_a - d0, 32'd1);
    check("t5_sh_rises", rises_a - r0, 32'd16);
    check("t5_st_rises", st_rises_a - s0, 32'd1);
    check("t5_idle", 32'(busy_a), 32'd0);

    // Reset during bit 7 aborts the frame without a latch pulse.
    r0 = rises_a; s0 = st_rises_a;
    pulse_load_a(16'hF00F, e0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (rises_a - r0 >= 7) seen = 1'b1;
    end
    check("t6_reach_bit7", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", 32'({busy_a, done_a, sh_cp_a, st_cp_a, ds_a}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6_no_latch", st_rises_a - s0, 32'd0);
    r0 = rises_a; s0 = st_rises_a;
    pulse_load_a(16'h1234, e0);
    wait_done_a("t6", ed);
    check("t6_done_latency", ed - e0, 32'd66);
    check("t6_ds_word", 32'(cap_a), 32'h1234);
    check("t6_sh_rises", rises_a - r0, 32'd16);
    check("t6_st_rises", st_rises_a - s0, 32'd1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
